// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and issues one instruction-memory read at a time.
// The instruction shown on INSTR_F feeds the F/D register, which captures it
// on the falling edge of CLK. Every cycle without a freshly fetched (or
// stalled) instruction shows the NOP_INSTR bubble.
//
// Handshake: IMEM_REQ is a one-cycle pulse with IMEM_ADDR valid in that same
// cycle; the memory answers with a one-cycle IMEM_VALID pulse (carrying
// IMEM_RDATA) one or more cycles later. At most one read is ever outstanding,
// and IMEM_VALID outside WAIT/DROP is ignored.
module fetch_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = '1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             STALL_F,
    input  logic             BRANCH_TAKEN_E,
    input  logic [WIDTH-1:0] BRANCH_TARGET_E,
    output logic             IMEM_REQ,
    output logic [WIDTH-1:0] IMEM_ADDR,
    input  logic             IMEM_VALID,
    input  logic [WIDTH-1:0] IMEM_RDATA,
    output logic [WIDTH-1:0] INSTR_F,
    output logic [WIDTH-1:0] PCPLUS4_F,
    output logic [WIDTH-1:0] PC_F
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // issue the read for PC_F this cycle
        S_WAIT = 2'd1,  // read outstanding, data will be shown
        S_HOLD = 2'd2,  // decode stalled, keep showing the captured instruction
        S_DROP = 2'd3   // read outstanding, data belongs to a squashed path
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc_plus4;

    // Modulo-2^WIDTH increment; wraps 0xFFFF_FFFC to 0 naturally.
    assign pc_plus4 = PC_F + WIDTH'(4);

    // The request pulse is tied to the REQ state; masked by CLR so the reset
    // state (which is REQ) never shows a request while reset is held.
    assign IMEM_REQ  = (state == S_REQ) && !CLR;
    assign IMEM_ADDR = IMEM_REQ ? PC_F : '0;

    // Fetch FSM: PC, shown instruction and its PC+4; redirect beats stall and data.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= S_REQ;
            PC_F      <= RESET_PC;
            INSTR_F   <= NOP_INSTR;
            PCPLUS4_F <= '0;
        end else begin
            // Bubble unless a branch below explicitly shows or holds an instruction.
            INSTR_F <= NOP_INSTR;
            if (BRANCH_TAKEN_E) begin
                PC_F <= BRANCH_TARGET_E;
                case (state)
                    // The read issued this cycle is still in flight.
                    S_REQ:   state <= S_DROP;
                    // If data arrives now the read is finished and simply
                    // discarded; otherwise its reply still has to be drained.
                    S_WAIT:  state <= IMEM_VALID ? S_REQ : S_DROP;
                    S_DROP:  state <= IMEM_VALID ? S_REQ : S_DROP;
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_REQ: state <= S_WAIT;
                    S_WAIT: begin
                        if (IMEM_VALID) begin
                            INSTR_F   <= IMEM_RDATA;
                            PCPLUS4_F <= pc_plus4;
                            if (STALL_F) begin
                                state <= S_HOLD;
                            end else begin
                                PC_F  <= pc_plus4;
                                state <= S_REQ;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (STALL_F) begin
                            INSTR_F <= INSTR_F;
                        end else begin
                            // Instruction already consumed during the stall;
                            // the following REQ cycle shows a bubble.
                            PC_F  <= pc_plus4;
                            state <= S_REQ;
                        end
                    end
                    default: begin
                        if (IMEM_VALID) state <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level reference model (outstanding /
// squashed / held flags) plus a small latency-configurable memory responder.
// Two DUT instances: default RESET_PC and RESET_PC = 0xFFFF_FFFC.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'hFFFF_FFFF;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  // ---------------- clock / reset / signals
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic stall = 1'b0;
  logic br = 1'b0;
  logic [31:0] tgt = '0;
  logic valid = 1'b0;
  logic [31:0] rdata = '0;
  logic sel = 1'b0;

  logic req0, req1;
  logic [31:0] addr0, addr1, instr0, instr1, pp40, pp41, pc0, pc1;

  always #5 clk = ~clk;

  fetch_unit dut0 (
    .CLK(clk), .CLR(clr), .STALL_F(stall), .BRANCH_TAKEN_E(br),
    .BRANCH_TARGET_E(tgt), .IMEM_REQ(req0), .IMEM_ADDR(addr0),
    .IMEM_VALID(valid), .IMEM_RDATA(rdata), .INSTR_F(instr0),
    .PCPLUS4_F(pp40), .PC_F(pc0)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut1 (
    .CLK(clk), .CLR(clr), .STALL_F(stall), .BRANCH_TAKEN_E(br),
    .BRANCH_TARGET_E(tgt), .IMEM_REQ(req1), .IMEM_ADDR(addr1),
    .IMEM_VALID(valid), .IMEM_RDATA(rdata), .INSTR_F(instr1),
    .PCPLUS4_F(pp41), .PC_F(pc1)
  );

  logic obs_req;
  logic [31:0] obs_addr, obs_instr, obs_pp4, obs_pc;
  assign obs_req   = sel ? req1 : req0;
  assign obs_addr  = sel ? addr1 : addr0;
  assign obs_instr = sel ? instr1 : instr0;
  assign obs_pp4   = sel ? pp41 : pp40;
  assign obs_pc    = sel ? pc1 : pc0;

  // ---------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];   // addresses the model expects to be requested

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // ---------------- memory responder
  int mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int lat_cfg = 1;     // 0 = random 1..4
  bit data_mode = 0;   // 0 = every word is 0x13, 1 = address-derived words

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return data_mode ? (a ^ 32'h5A5A_0F0F) : 32'h0000_0013;
  endfunction

  // ---------------- reference model
  logic [31:0] m_pc, m_instr, m_pp4;
  bit m_out, m_drop, m_hold;

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_instr = NOP; m_pp4 = '0;
    m_out = 0; m_drop = 0; m_hold = 0;
    mem_cnt = 0;
    exp_q.delete();
  endtask

  // One clock of fetch behaviour, given this cycle's inputs.
  task automatic model_step(input bit s, input bit b, input logic [31:0] t,
                            input bit v, input logic [31:0] d);
    bit req_now;
    bit reply;
    req_now = !m_out && !m_hold;
    reply = m_out && v;
    if (b) begin
      m_pc = t; m_instr = NOP; m_hold = 0;
      m_out = req_now || (m_out && !v);
      m_drop = m_out;
    end else if (m_hold) begin
      if (!s) begin m_hold = 0; m_pc = m_pc + 32'd4; m_instr = NOP; end
    end else if (req_now) begin
      m_out = 1; m_drop = 0; m_instr = NOP;
    end else if (reply) begin
      m_out = 0;
      if (m_drop) begin
        m_drop = 0; m_instr = NOP;
      end else begin
        m_instr = d; m_pp4 = m_pc + 32'd4;
        if (s) m_hold = 1; else m_pc = m_pc + 32'd4;
      end
    end else begin
      m_instr = NOP;
    end
  endtask

  // ---------------- driver tasks
  task automatic do_reset(input bit which, input logic [31:0] rpc);
    sel = which;
    clr = 1'b1; stall = 0; br = 0; valid = 0; tgt = '0;
    @(negedge clk);
    chk("rst_req", {31'd0, obs_req}, 32'd0);
    chk("rst_addr", obs_addr, 32'd0);
    chk("rst_instr", obs_instr, NOP);
    chk("rst_pp4", obs_pp4, 32'd0);
    chk("rst_pc", obs_pc, rpc);
    model_reset(rpc);
    clr = 1'b0;
  endtask

  // Check this cycle's outputs, drive this cycle's inputs, advance the model,
  // and return at the next falling edge.
  task automatic cycle(input bit s, input bit b, input logic [31:0] t);
    bit exp_req;
    bit v;
    #1;
    exp_req = !m_out && !m_hold;
    chk("req", {31'd0, obs_req}, {31'd0, exp_req});
    if (exp_req) exp_q.push_back(m_pc);
    if (obs_req) begin
      if (exp_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
      else chk("req_addr", obs_addr, exp_q.pop_front());
    end
    exp_q.delete();
    chk("instr", obs_instr, m_instr);
    chk("pcplus4", obs_pp4, m_pp4);
    chk("pc", obs_pc, m_pc);

    v = 0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) v = 1;
    end
    stall = s; br = b; tgt = t; valid = v;
    rdata = v ? mem_data(mem_addr) : $urandom;
    model_step(s, b, t, v, rdata);
    if (obs_req) begin
      mem_addr = obs_addr;
      mem_cnt = (lat_cfg == 0) ? $urandom_range(1, 4) : lat_cfg;
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus
  initial begin
    // Phase 1: RESET_PC = 0
    do_reset(1'b0, 32'd0);
    lat_cfg = 1; data_mode = 0;
    for (int i = 0; i < 5; i++) cycle(0, 0, '0);      // c0..c4: PC 0,4 fetched, req at 8
    cycle(1, 0, '0);                                    // c5: data for PC 8 with stall
    cycle(1, 0, '0);                                    // c6
    cycle(1, 0, '0);                                    // c7
    cycle(0, 0, '0);                                    // c8: stall released
    chk("after_stall_req", {31'd0, obs_req}, 32'd1);
    chk("after_stall_addr", obs_addr, 32'd12);

    // Redirect while waiting on a 2-cycle read.
    lat_cfg = 2; data_mode = 1;
    cycle(0, 0, '0);                                    // REQ for PC 12
    cycle(0, 1, 32'h100);                               // WAIT, redirect
    cycle(0, 0, '0);                                    // DROP drains the stale reply
    chk("redir_addr", obs_addr, 32'h100);
    chk("redir_instr", obs_instr, NOP);
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    cycle(0, 0, '0);                                    // data for 0x100 arrives
    chk("redir_pp4", obs_pp4, 32'h104);
    chk("redir_data", obs_instr, 32'h100 ^ 32'h5A5A_0F0F);

    // Redirect together with stall while holding.
    lat_cfg = 1;
    cycle(0, 0, '0);                                    // REQ for 0x104
    cycle(1, 0, '0);                                    // data with stall -> hold
    cycle(1, 1, 32'h200);                               // redirect during hold
    chk("hold_redir_instr", obs_instr, NOP);
    chk("hold_redir_addr", obs_addr, 32'h200);

    // Randomized traffic.
    lat_cfg = 0;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            {$urandom_range(0, 32'h3FFF), 2'b00});
    end

    // Phase 2: RESET_PC = 0xFFFF_FFFC
    lat_cfg = 1; data_mode = 1;
    do_reset(1'b1, WRAP_PC);
    cycle(0, 0, '0);                                    // REQ at 0xFFFF_FFFC
    cycle(0, 0, '0);                                    // data returns
    chk("wrap_pp4", obs_pp4, 32'd0);
    chk("wrap_addr", obs_addr, 32'd0);
    chk("wrap_instr", obs_instr, WRAP_PC ^ 32'h5A5A_0F0F);
    lat_cfg = 3;
    cycle(0, 0, '0);                                    // REQ at 0, now waiting
    #2 clr = 1'b1;
    #1;
    chk("clr_req", {31'd0, obs_req}, 32'd0);
    chk("clr_instr", obs_instr, NOP);
    chk("clr_pc", obs_pc, WRAP_PC);
    valid = 0; stall = 0; br = 0;
    model_reset(WRAP_PC);
    @(negedge clk);
    clr = 1'b0;
    lat_cfg = 0;
    for (int i = 0; i < 60; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            {$urandom_range(0, 32'h3FFF), 2'b00});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
